// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter slice.
package wb_pkg;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NREGS  = 1 << ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_t;

    function automatic logic [NREGS-1:0] reg_onehot(input logic [ADDR_W-1:0] a);
        logic [NREGS-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Result streams in, register-bank write port and pending mask out.
interface wb_arbiter_if;
    import wb_pkg::*;

    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              wb_hold;
    logic              we3;
    logic [ADDR_W-1:0] wa3;
    logic [DATA_W-1:0] wd3;
    logic [NREGS-1:0]  pending_mask;

    modport master (
        output alu_valid, alu_addr, alu_data,
        output mem_valid, mem_addr, mem_data,
        output wb_hold,
        input  alu_ready, mem_ready,
        input  we3, wa3, wd3, pending_mask
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  mem_valid, mem_addr, mem_data,
        input  wb_hold,
        output alu_ready, mem_ready,
        output we3, wa3, wd3, pending_mask
    );

endinterface

// File: rtl/wb_fifo.sv
// Per-source result FIFO; exposes per-slot valid bits and addresses for the pending mask.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  wb_entry_t         din,
    output wb_entry_t         dout,
    output logic              empty,
    output logic              full,
    output logic [DEPTH-1:0]  valid,
    output logic [ADDR_W-1:0] addrs [DEPTH]
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    wb_entry_t        store [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic [DEPTH-1:0] valid_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = store[rptr];
    assign valid   = valid_q;

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            addrs[i] = store[i].addr;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wptr] <= din;
        end
    end

    // Pop clears its slot before push sets one; they never alias since
    // push needs !full and pop needs !empty when pointers are equal.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            valid_q <= '0;
        end else begin
            if (do_pop) begin
                valid_q[rptr] <= 1'b0;
                rptr          <= rptr + 1'b1;
            end
            if (do_push) begin
                valid_q[wptr] <= 1'b1;
                wptr          <= wptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback stage: two buffered result streams, round-robin onto one register write port.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);

    wb_entry_t         alu_din;
    wb_entry_t         mem_din;
    wb_entry_t         alu_head;
    wb_entry_t         mem_head;
    logic              alu_empty;
    logic              alu_full;
    logic              mem_empty;
    logic              mem_full;
    logic [DEPTH-1:0]  alu_vld;
    logic [DEPTH-1:0]  mem_vld;
    logic [ADDR_W-1:0] alu_addrs [DEPTH];
    logic [ADDR_W-1:0] mem_addrs [DEPTH];
    logic              alu_push;
    logic              mem_push;
    logic              grant_alu;
    logic              grant_mem;
    src_t              last_grant;
    src_t              last_grant_nxt;
    logic              we3_q;
    logic [ADDR_W-1:0] wa3_q;
    logic [DATA_W-1:0] wd3_q;
    logic [NREGS-1:0]  mask;

    assign bus.alu_ready = ~alu_full;
    assign bus.mem_ready = ~mem_full;
    assign alu_push      = bus.alu_valid & ~alu_full;
    assign mem_push      = bus.mem_valid & ~mem_full;
    assign alu_din       = '{addr: bus.alu_addr, data: bus.alu_data};
    assign mem_din       = '{addr: bus.mem_addr, data: bus.mem_data};

    wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (alu_push),
        .pop   (grant_alu),
        .din   (alu_din),
        .dout  (alu_head),
        .empty (alu_empty),
        .full  (alu_full),
        .valid (alu_vld),
        .addrs (alu_addrs)
    );

    wb_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (mem_push),
        .pop   (grant_mem),
        .din   (mem_din),
        .dout  (mem_head),
        .empty (mem_empty),
        .full  (mem_full),
        .valid (mem_vld),
        .addrs (mem_addrs)
    );

    // last_grant only moves when both sources contend.
    always_comb begin
        grant_alu      = 1'b0;
        grant_mem      = 1'b0;
        last_grant_nxt = last_grant;
        if (!bus.wb_hold) begin
            if (!alu_empty && !mem_empty) begin
                if (last_grant == SRC_MEM) begin
                    grant_alu      = 1'b1;
                    last_grant_nxt = SRC_ALU;
                end else begin
                    grant_mem      = 1'b1;
                    last_grant_nxt = SRC_MEM;
                end
            end else if (!alu_empty) begin
                grant_alu = 1'b1;
            end else if (!mem_empty) begin
                grant_mem = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant <= SRC_MEM;
        end else begin
            last_grant <= last_grant_nxt;
        end
    end

    // wa3/wd3 keep their last value on idle cycles; only we3 drops.
    always_ff @(posedge clk) begin
        if (!rst) begin
            we3_q <= 1'b0;
            wa3_q <= '0;
            wd3_q <= '0;
        end else if (grant_alu) begin
            we3_q <= 1'b1;
            wa3_q <= alu_head.addr;
            wd3_q <= alu_head.data;
        end else if (grant_mem) begin
            we3_q <= 1'b1;
            wa3_q <= mem_head.addr;
            wd3_q <= mem_head.data;
        end else begin
            we3_q <= 1'b0;
        end
    end

    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (alu_vld[i]) mask = mask | reg_onehot(alu_addrs[i]);
            if (mem_vld[i]) mask = mask | reg_onehot(mem_addrs[i]);
        end
        if (we3_q) mask = mask | reg_onehot(wa3_q);
    end

    assign bus.we3          = we3_q;
    assign bus.wa3          = wa3_q;
    assign bus.wd3          = wd3_q;
    assign bus.pending_mask = mask;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed and randomized checks of wb_arbiter against a queue-based reference model.
module tb_wb_arbiter;
    import wb_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    wb_arbiter_if bus ();

    wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [35:0] qa[$];
    logic [35:0] qm[$];
    bit          m_last_mem;
    logic        m_we;
    logic [3:0]  m_wa;
    logic [31:0] m_wd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [35:0] e;
        int          pick;
        bit          acc_a;
        bit          acc_m;
        if (!rst) begin
            qa.delete();
            qm.delete();
            m_we       = 1'b0;
            m_wa       = '0;
            m_wd       = '0;
            m_last_mem = 1'b1;
        end else begin
            pick  = 0;
            acc_a = bus.alu_valid && (qa.size() < DEPTH);
            acc_m = bus.mem_valid && (qm.size() < DEPTH);
            if (!bus.wb_hold) begin
                if (qa.size() > 0 && qm.size() > 0) begin
                    pick       = m_last_mem ? 1 : 2;
                    m_last_mem = (pick == 2);
                end else if (qa.size() > 0) pick = 1;
                else if (qm.size() > 0) pick = 2;
            end
            if (pick == 1) e = qa.pop_front();
            if (pick == 2) e = qm.pop_front();
            if (pick != 0) begin
                m_we = 1'b1;
                m_wa = e[35:32];
                m_wd = e[31:0];
            end else begin
                m_we = 1'b0;
            end
            if (acc_a) qa.push_back({bus.alu_addr, bus.alu_data});
            if (acc_m) qm.push_back({bus.mem_addr, bus.mem_data});
        end
    endtask

    function automatic logic [15:0] model_mask();
        logic [15:0] m;
        m = '0;
        foreach (qa[i]) m[qa[i][35:32]] = 1'b1;
        foreach (qm[i]) m[qm[i][35:32]] = 1'b1;
        if (m_we) m[m_wa] = 1'b1;
        return m;
    endfunction

    task automatic check_all();
        chk("we3", bus.we3, m_we);
        chk("wa3", bus.wa3, m_wa);
        chk("wd3", bus.wd3, m_wd);
        chk("pending_mask", bus.pending_mask, model_mask());
        chk("alu_ready", bus.alu_ready, qa.size() < DEPTH);
        chk("mem_ready", bus.mem_ready, qm.size() < DEPTH);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        bus.alu_valid = 1'b0;
        bus.mem_valid = 1'b0;
        bus.wb_hold   = 1'b0;
        bus.alu_addr  = '0;
        bus.alu_data  = '0;
        bus.mem_addr  = '0;
        bus.mem_data  = '0;
    endtask

    initial begin
        // Reset with random inputs
        rst           = 1'b0;
        bus.alu_valid = 1'($urandom_range(0, 1));
        bus.mem_valid = 1'($urandom_range(0, 1));
        bus.wb_hold   = 1'($urandom_range(0, 1));
        bus.alu_addr  = 4'($urandom);
        bus.alu_data  = $urandom;
        bus.mem_addr  = 4'($urandom);
        bus.mem_data  = $urandom;
        cycle();
        cycle();
        chk("rst_we3", bus.we3, 1'b0);
        chk("rst_wa3", bus.wa3, 4'h0);
        chk("rst_wd3", bus.wd3, 32'h0);
        chk("rst_mask", bus.pending_mask, 16'h0);
        rst = 1'b1;
        idle_inputs();
        #1;
        chk("rst_alu_ready", bus.alu_ready, 1'b1);
        chk("rst_mem_ready", bus.mem_ready, 1'b1);
        cycle();

        // Single ALU write
        bus.alu_valid = 1'b1;
        bus.alu_addr  = 4'd3;
        bus.alu_data  = 32'hFF;
        cycle();
        bus.alu_valid = 1'b0;
        chk("single_mask_q", bus.pending_mask, 16'h0008);
        chk("single_we_q", bus.we3, 1'b0);
        cycle();
        chk("single_we", bus.we3, 1'b1);
        chk("single_wa", bus.wa3, 4'd3);
        chk("single_wd", bus.wd3, 32'hFF);
        chk("single_mask_p", bus.pending_mask, 16'h0008);
        cycle();
        chk("single_we_off", bus.we3, 1'b0);
        chk("single_mask_clr", bus.pending_mask, 16'h0);

        // Contention: alternate ALU/MEM back to back
        bus.alu_addr = 4'd1;
        bus.alu_data = 32'h11;
        bus.mem_addr = 4'd2;
        bus.mem_data = 32'h22;
        for (int k = 0; k < 9; k++) begin
            bus.alu_valid = (k < 3);
            bus.mem_valid = (k < 3);
            cycle();
            if (k >= 1 && k <= 6) begin
                chk("rr_we", bus.we3, 1'b1);
                chk("rr_wa", bus.wa3, (k % 2 == 1) ? 4'd1 : 4'd2);
                chk("rr_wd", bus.wd3, (k % 2 == 1) ? 32'h11 : 32'h22);
            end
        end
        idle_inputs();
        cycle();

        // Full under hold
        bus.wb_hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.alu_valid = 1'b1;
            bus.alu_addr  = 4'(4 + i);
            bus.alu_data  = 32'(i);
            chk("full_ready", bus.alu_ready, i < 4);
            cycle();
        end
        bus.alu_valid = 1'b0;
        chk("full_ready_low", bus.alu_ready, 1'b0);
        chk("full_mask", bus.pending_mask, 16'h00F0);
        bus.wb_hold = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            if (k < 4) begin
                chk("drain_we", bus.we3, 1'b1);
                chk("drain_wa", bus.wa3, 4'(4 + k));
            end else begin
                chk("drain_we_off", bus.we3, 1'b0);
            end
        end

        // Mid-operation reset discards queued MEM entries
        bus.wb_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.mem_valid = 1'b1;
            bus.mem_addr  = 4'(9 + i);
            bus.mem_data  = 32'hA0 + 32'(i);
            cycle();
        end
        bus.mem_valid = 1'b0;
        chk("midrst_mask_pre", bus.pending_mask, 16'h0E00);
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        bus.wb_hold = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("midrst_we", bus.we3, 1'b0);
            chk("midrst_mask", bus.pending_mask, 16'h0);
            chk("midrst_ready", bus.mem_ready, 1'b1);
        end

        // Address 15 treated like any other register
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 4'hF;
        bus.mem_data  = 32'hFF;
        cycle();
        bus.mem_valid = 1'b0;
        chk("vga_mask_q", bus.pending_mask, 16'h8000);
        cycle();
        chk("vga_we", bus.we3, 1'b1);
        chk("vga_wa", bus.wa3, 4'hF);
        chk("vga_wd", bus.wd3, 32'hFF);
        chk("vga_mask_p", bus.pending_mask, 16'h8000);
        cycle();
        chk("vga_mask_clr", bus.pending_mask, 16'h0);

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            bus.alu_valid = 1'($urandom_range(0, 1));
            bus.mem_valid = 1'($urandom_range(0, 1));
            bus.alu_addr  = 4'($urandom);
            bus.alu_data  = $urandom;
            bus.mem_addr  = 4'($urandom);
            bus.mem_data  = $urandom;
            bus.wb_hold   = ($urandom_range(0, 3) == 0);
            rst           = ($urandom_range(0, 63) != 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
